// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryption core. One shared round datapath
// (SubBytes, ShiftRows, MixColumns, AddRoundKey) is reused for all NR rounds.
// Each round takes two cycles: SUB (registered S-box lookup) then MIX.
//
// Optional feature: define AES_ROUND_ENGINE_TRACE_EN to add trc_valid/trc_state.
// These ports pulse with every state-register write, for round-level observation.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    plaintext handshake; in_data is byte 0 in [127:120], column-major
//   rk_idx/rk_data       round-key index out, round key in (same-cycle combinational)
//   out_valid/out_ready  ciphertext handshake; out_data uses the same byte order
//   busy                 high whenever the FSM is not in IDLE
//   trc_valid/trc_state  (trace build only) state-register write pulse and value

package aes_round_engine_pkg;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (a^254) followed by the affine map.
  // a^254 = a^2 * a^4 * ... * a^128; this maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte (r,c) sits at index r+4c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// aes_sbox: one registered S-box lookup. dout updates only while en is high.
// Ports: clk, rst, en (sample strobe), din (byte in), dout (registered S-box byte).
module aes_sbox (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  import aes_round_engine_pkg::*;

  // Registered lookup, held between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 8'h00;
    end else if (en) begin
      dout <= sbox(din);
    end else begin
      dout <= dout;
    end
  end
endmodule

module aes_round_engine #(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  output logic [RKW-1:0] rk_idx,
  input  logic [127:0]   rk_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic           busy
`ifdef AES_ROUND_ENGINE_TRACE_EN
  ,
  output logic           trc_valid,
  output logic [127:0]   trc_state
`endif
);
  import aes_round_engine_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } fsm_t;

  localparam logic [RKW-1:0] LAST_ROUND = RKW'(NR);
  localparam logic [RKW-1:0] ONE        = RKW'(1);

  fsm_t           fsm;
  logic [RKW-1:0] round;
  logic [127:0]   state;
  logic [127:0]   sb_out;
  logic [127:0]   shifted;
  logic [127:0]   rnd_out;
  logic           sb_en;

  assign sb_en = (fsm == SUB);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .clk  (clk),
      .rst  (rst),
      .en   (sb_en),
      .din  (state[127-8*i -: 8]),
      .dout (sb_out[127-8*i -: 8])
    );
  end

  // Round datapath after the S-box stage; the final round skips MixColumns.
  always_comb begin
    shifted = shift_rows(sb_out);
    if (round == LAST_ROUND) begin
      rnd_out = shifted ^ rk_data;
    end else begin
      rnd_out = mix_columns(shifted) ^ rk_data;
    end
  end

  // Control FSM with registered handshake, key-index and status outputs.
  // rk_idx is loaded one cycle ahead so it already shows the round's index in SUB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      state     <= 128'h0;
      round     <= '0;
      out_valid <= 1'b0;
      out_data  <= 128'h0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      rk_idx    <= '0;
`ifdef AES_ROUND_ENGINE_TRACE_EN
      trc_valid <= 1'b0;
      trc_state <= 128'h0;
`endif
    end else begin
`ifdef AES_ROUND_ENGINE_TRACE_EN
      trc_valid <= 1'b0;
`endif
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state    <= in_data ^ rk_data;
            round    <= ONE;
            rk_idx   <= ONE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            fsm      <= SUB;
`ifdef AES_ROUND_ENGINE_TRACE_EN
            trc_valid <= 1'b1;
            trc_state <= in_data ^ rk_data;
`endif
          end else begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            rk_idx   <= '0;
          end
        end
        SUB: begin
          fsm <= MIX;
        end
        MIX: begin
          state <= rnd_out;
`ifdef AES_ROUND_ENGINE_TRACE_EN
          trc_valid <= 1'b1;
          trc_state <= rnd_out;
`endif
          if (round < LAST_ROUND) begin
            round  <= round + ONE;
            rk_idx <= round + ONE;
            fsm    <= SUB;
          end else begin
            out_data  <= rnd_out;
            out_valid <= 1'b1;
            rk_idx    <= '0;
            fsm       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          rk_idx    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
`timescale 1ns/1ps
module tb_aes_round_engine;

  localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_C256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] TRC_FIRST = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv   [0:1];
  logic         ir   [0:1];
  logic [127:0] idat [0:1];
  logic [3:0]   rki  [0:1];
  logic [127:0] rkd  [0:1];
  logic         ov   [0:1];
  logic         ordy [0:1];
  logic [127:0] odat [0:1];
  logic         bsy  [0:1];
`ifdef AES_ROUND_ENGINE_TRACE_EN
  logic         tv   [0:1];
  logic [127:0] ts   [0:1];
`endif

  logic [127:0] rks [0:1][0:15];
  assign rkd[0] = rks[0][rki[0]];
  assign rkd[1] = rks[1][rki[1]];

  aes_round_engine #(.NR(10), .RKW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
    .rk_idx(rki[0]), .rk_data(rkd[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(odat[0]), .busy(bsy[0])
`ifdef AES_ROUND_ENGINE_TRACE_EN
    , .trc_valid(tv[0]), .trc_state(ts[0])
`endif
  );

  aes_round_engine #(.NR(14), .RKW(4)) dut14 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
    .rk_idx(rki[1]), .rk_data(rkd[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(odat[1]), .busy(bsy[1])
`ifdef AES_ROUND_ENGINE_TRACE_EN
    , .trc_valid(tv[1]), .trc_state(ts[1])
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_hs = 0;
  int max_rk = 0;
  int trc_cnt = 0;
  logic [127:0] trc_first = 128'h0;
  logic [127:0] trc_last = 128'h0;
  logic [1:0]   ov_prev = 2'b00;
  logic [127:0] exp_q [$];
  int           acc_q [$];

  logic [7:0] sb [0:255];
  logic [7:0] ex [0:255];
  logic [7:0] lg [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] p);
    return {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box built from exp/log tables over generator 3, then the affine map.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = 8'(i);
      p = p ^ xt(p);
    end
    for (int a = 0; a < 256; a++) begin
      b = (a == 0) ? 8'h00 : ex[(255 - int'(lg[a])) % 255];
      sb[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Standard key schedule into the round-key table of DUT d.
  task automatic expand(input logic [255:0] key, input int nk, input int d);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rks[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Offer a block; push its expected ciphertext on the acceptance cycle.
  task automatic send(input int d, input logic [127:0] pt, input logic [127:0] ct,
                      input bit push, input bit hold, input bit swap_b);
    bit done;
    done = 1'b0;
    idat[d] = pt;
    iv[d] = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      if (ir[d]) begin
        done = 1'b1;
        acc_cyc = cyc;
        if (push) exp_q.push_back(ct);
      end else if (swap_b && ov[d]) begin
        expand({KEY_B, 128'h0}, 4, d);
      end
      @(negedge clk);
    end
    if (!hold) iv[d] = 1'b0;
    check_vec("accept", 128'(done), 128'(1));
  endtask

  task automatic wait_done(input int d);
    bit fin;
    fin = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      @(negedge clk);
      fin = !bsy[d] && !ov[d];
    end
    check_vec("block_done", 128'(fin), 128'(1));
  endtask

  // Output monitor: latency from acceptance, scoreboard pop on handshake.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      acc_q.delete();
      ov_prev = 2'b00;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (iv[d] && ir[d]) acc_q.push_back(cyc);
        if (ov[d] && !ov_prev[d]) begin
          check_vec("acc_pending", 128'(acc_q.size() > 0), 128'(1));
          if (acc_q.size() > 0)
            check_vec("latency", 128'(cyc - acc_q.pop_front()), 128'((d == 0) ? 21 : 29));
        end
        if (ov[d] && ordy[d]) begin
          last_hs = cyc;
          check_vec("exp_pending", 128'(exp_q.size() > 0), 128'(1));
          if (exp_q.size() > 0)
            check_vec((d == 0) ? "ct_nr10" : "ct_nr14", odat[d], exp_q.pop_front());
        end
        ov_prev[d] = ov[d];
      end
      if (int'(rki[0]) > max_rk) max_rk = int'(rki[0]);
`ifdef AES_ROUND_ENGINE_TRACE_EN
      if (tv[0]) begin
        if (trc_cnt == 0) trc_first = ts[0];
        trc_last = ts[0];
        trc_cnt++;
      end
`endif
    end
  end

  initial begin
    bit hit;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      idat[d] = 128'h0;
      ordy[d] = 1'b1;
    end
    build_sbox();
    expand({KEY_B, 128'h0}, 4, 0);
    expand(KEY_C256, 8, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_vec("rst_in_ready", 128'(ir[0]), 128'(1));
    check_vec("rst_out_valid", 128'(ov[0]), 128'(0));
    check_vec("rst_out_data", odat[0], 128'h0);
    check_vec("rst_busy", 128'(bsy[0]), 128'(0));
    check_vec("rst_rk_idx", 128'(rki[0]), 128'(0));

    // FIPS-197 App. B
    trc_cnt = 0;
    send(0, PT_B, CT_B, 1'b1, 1'b0, 1'b0);
    wait_done(0);
`ifdef AES_ROUND_ENGINE_TRACE_EN
    check_vec("trc_count", 128'(trc_cnt), 128'(11));
    check_vec("trc_first", trc_first, TRC_FIRST);
    check_vec("trc_last", trc_last, CT_B);
`endif

    // FIPS-197 App. C.1 (AES-128) and App. C.3 (AES-256)
    expand({KEY_C128, 128'h0}, 4, 0);
    send(0, PT_C, CT_C128, 1'b1, 1'b0, 1'b0);
    wait_done(0);
    send(1, PT_C, CT_C256, 1'b1, 1'b0, 1'b0);
    wait_done(1);

    // Backpressure: sink stalls 15 cycles, then a single-cycle out_ready pulse
    ordy[0] = 1'b0;
    send(0, PT_C, CT_C128, 1'b1, 1'b0, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      if (ov[0]) hit = 1'b1;
      else @(negedge clk);
    end
    check_vec("bp_out_valid_seen", 128'(hit), 128'(1));
    for (int k = 0; k < 15; k++) begin
      check_vec("bp_hold_valid", 128'(ov[0]), 128'(1));
      check_vec("bp_hold_data", odat[0], CT_C128);
      check_vec("bp_in_ready", 128'(ir[0]), 128'(0));
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    check_vec("bp_valid_drop", 128'(ov[0]), 128'(0));
    check_vec("bp_ready_back", 128'(ir[0]), 128'(1));
    ordy[0] = 1'b1;
    @(negedge clk);

    // Back-to-back with in_valid held high; key table swapped while first block waits in DONE
    send(0, PT_C, CT_C128, 1'b1, 1'b1, 1'b0);
    send(0, PT_B, CT_B, 1'b1, 1'b0, 1'b1);
    check_vec("b2b_gap", 128'(acc_cyc - last_hs), 128'(1));
    wait_done(0);

    // Reset during MIX of round 5 aborts the block
    send(0, PT_B, CT_B, 1'b0, 1'b0, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      if (rki[0] == 4'd5) hit = 1'b1;
      else @(negedge clk);
    end
    check_vec("reach_round5", 128'(hit), 128'(1));
    @(negedge clk);
    check_vec("pre_rst_busy", 128'(bsy[0]), 128'(1));
    #2 rst = 1'b1;
    #1;
    check_vec("arst_out_valid", 128'(ov[0]), 128'(0));
    check_vec("arst_busy", 128'(bsy[0]), 128'(0));
    check_vec("arst_rk_idx", 128'(rki[0]), 128'(0));
    check_vec("arst_in_ready", 128'(ir[0]), 128'(1));
    check_vec("arst_out_data", odat[0], 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, PT_B, CT_B, 1'b1, 1'b0, 1'b0);
    wait_done(0);

    check_vec("rk_idx_max", 128'(max_rk), 128'(10));
    check_vec("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
